// File: rtl/cache_repl_if.sv
// Access-side signals of the cache replacement selector. Master drives the
// access/fill controls, slave (cache_repl) returns the one-hot victim.
interface cache_repl_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7
);
  // No handshake: controls are sampled on every rising clk edge, and
  // VictimWay is a purely combinational response that is always valid.
  logic               CacheEn;
  logic [SETLEN-1:0]  CacheSet;
  logic [NUMWAYS-1:0] ValidWay;
  logic               FillEn;
  logic               FlushStage;
  logic               InvalidateCache;
  logic               PolicySel;
  logic [NUMWAYS-1:0] VictimWay;

  modport master (
    output CacheEn, CacheSet, ValidWay, FillEn, FlushStage, InvalidateCache, PolicySel,
    input  VictimWay
  );

  modport slave (
    input  CacheEn, CacheSet, ValidWay, FillEn, FlushStage, InvalidateCache, PolicySel,
    output VictimWay
  );
endinterface

// File: rtl/cache_repl.sv
// Victim-way selector: first invalid way, else LFSR random or per-set round-robin.
// Macro CACHE_REPL_RR_EN adds the per-set round-robin pointers and enables PolicySel/InvalidateCache.
module cache_repl #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 7,
  parameter int LFSRWIDTH = 8,
  parameter int SEED      = 1
) (
  input logic         clk,
  input logic         resetn,
  cache_repl_if.slave bus
);
  localparam int LOGNUMWAYS = $clog2(NUMWAYS);
  localparam int NUMLINES   = 2 ** SETLEN;
  localparam logic [LFSRWIDTH-1:0] SEED_M = LFSRWIDTH'(SEED);

  if (SEED_M == '0) begin : g_bad_seed
    $error("cache_repl: SEED masked to LFSRWIDTH must be nonzero");
  end
  if (LFSRWIDTH != 8 && LFSRWIDTH != 16) begin : g_bad_lfsr
    $error("cache_repl: LFSRWIDTH must be 8 or 16");
  end
  if (NUMWAYS < 2 || NUMWAYS > 16 || (NUMWAYS & (NUMWAYS - 1)) != 0) begin : g_bad_ways
    $error("cache_repl: NUMWAYS must be a power of 2 in 2..16");
  end

  logic [SETLEN-1:0]     r_set;
  logic [LFSRWIDTH-1:0]  r_lfsr;
  logic                  w_fb;
  logic [LFSRWIDTH-1:0]  w_lfsr_nxt;
  logic                  w_all_valid;
  logic                  w_step;
  logic [LOGNUMWAYS-1:0] w_free_idx;
  logic [LOGNUMWAYS-1:0] w_full_idx;
  logic [LOGNUMWAYS-1:0] w_victim_idx;

  if (LFSRWIDTH == 16) begin : g_fb16
    assign w_fb = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
  end else begin : g_fb8
    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  end

  assign w_lfsr_nxt  = {r_lfsr[LFSRWIDTH-2:0], w_fb};
  assign w_all_valid = &bus.ValidWay;
  assign w_step      = bus.FillEn & ~bus.FlushStage;

  // Descending scan so the lowest-index invalid way is the one that sticks.
  always_comb begin
    w_free_idx = '0;
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!bus.ValidWay[i]) w_free_idx = LOGNUMWAYS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_set  <= '0;
      r_lfsr <= SEED_M;
    end else begin
      if (bus.CacheEn) r_set <= bus.CacheSet;
      if (w_step)      r_lfsr <= w_lfsr_nxt;
    end
  end

`ifdef CACHE_REPL_RR_EN
  logic [LOGNUMWAYS-1:0] r_ptr [NUMLINES];

  assign w_full_idx = bus.PolicySel ? r_ptr[r_set] : r_lfsr[LOGNUMWAYS-1:0];

  // Invalidate wins over the fill increment; flush freezes the whole array.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUMLINES; i++) r_ptr[i] <= '0;
    end else if (!bus.FlushStage) begin
      if (bus.InvalidateCache) begin
        for (int i = 0; i < NUMLINES; i++) r_ptr[i] <= '0;
      end else if (bus.FillEn && w_all_valid) begin
        r_ptr[r_set] <= r_ptr[r_set] + LOGNUMWAYS'(1);
      end
    end
  end
`else
  logic w_unused;

  assign w_unused   = &{1'b0, bus.PolicySel, bus.InvalidateCache};
  assign w_full_idx = r_lfsr[LOGNUMWAYS-1:0];
`endif

  assign w_victim_idx  = w_all_valid ? w_full_idx : w_free_idx;
  assign bus.VictimWay = NUMWAYS'(1) << w_victim_idx;

endmodule

// File: tb/tb_cache_repl.sv
// Randomized scoreboard bench for cache_repl (NUMWAYS=4, SETLEN=7, LFSRWIDTH=8, SEED=1).
module tb_cache_repl;
  localparam int NW = 4;
  localparam int SL = 7;
  localparam int NL = 128;
`ifdef CACHE_REPL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cache_repl_if #(.NUMWAYS(NW), .SETLEN(SL)) bus ();

  cache_repl #(.NUMWAYS(NW), .SETLEN(SL), .LFSRWIDTH(8), .SEED(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  logic [NW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  int m_lfsr;
  int m_set;
  int m_ptr [NL];

  function automatic void model_reset();
    m_lfsr = 1;
    m_set  = 0;
    for (int i = 0; i < NL; i++) m_ptr[i] = 0;
  endfunction

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic logic [NW-1:0] model_victim(input logic [NW-1:0] vw, input logic ps);
    int  idx;
    bit  found;
    found = 0;
    idx   = 0;
    for (int i = 0; i < NW; i++) begin
      if (!found && !vw[i]) begin
        idx   = i;
        found = 1;
      end
    end
    if (!found) idx = (RR && ps) ? m_ptr[m_set] : (m_lfsr % NW);
    return NW'(1 << idx);
  endfunction

  function automatic void model_edge(input logic rn, ce, input int cs, input logic [NW-1:0] vw,
                                     input logic fe, fl, inv);
    if (!rn) begin
      model_reset();
    end else begin
      if (!fl) begin
        if (fe) m_lfsr = lfsr_step(m_lfsr);
        if (RR) begin
          if (inv) begin
            for (int i = 0; i < NL; i++) m_ptr[i] = 0;
          end else if (fe && (vw == '1)) begin
            m_ptr[m_set] = (m_ptr[m_set] + 1) % NW;
          end
        end
      end
      if (ce) m_set = cs;
    end
  endfunction

  // One cycle: drive inputs, queue the expected victim for this cycle, advance the model.
  task automatic drive(input logic rn, ce, input int cs, input logic [NW-1:0] vw,
                       input logic fe, fl, inv, ps, input int force_exp);
    logic [NW-1:0] e;
    @(posedge clk);
    #1;
    resetn              = rn;
    bus.CacheEn         = ce;
    bus.CacheSet        = SL'(cs);
    bus.ValidWay        = vw;
    bus.FillEn          = fe;
    bus.FlushStage      = fl;
    bus.InvalidateCache = inv;
    bus.PolicySel       = ps;
    e = model_victim(vw, ps);
    if (force_exp >= 0) e = NW'(force_exp);
    exp_q.push_back(e);
    model_edge(rn, ce, cs, vw, fe, fl, inv);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0, '1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [NW-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (bus.VictimWay !== e) begin
        bad++;
        $display("FAIL victim t=%0t got=%b exp=%b", $time, bus.VictimWay, e);
      end
      total++;
      if (!$onehot(bus.VictimWay)) begin
        bad++;
        $display("FAIL onehot t=%0t got=%b", $time, bus.VictimWay);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_seq[5];
    int lfsr_seq[5];
    rr_seq   = '{1, 2, 4, 8, 1};
    lfsr_seq = '{2, 4, 1, 1, 2};
    bus.CacheEn = 1'b0;  bus.CacheSet = '0;  bus.ValidWay = '1;  bus.FillEn = 1'b0;
    bus.FlushStage = 1'b0;  bus.InvalidateCache = 1'b0;  bus.PolicySel = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // Random-policy sequence from reset.
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 4'b1111, 1, 0, 0, 0, lfsr_seq[i]);
    // Invalid way 2 always wins while the LFSR keeps stepping.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 4'b1011, 1, 0, 0, 0, 4'b0100);
    drive(1, 0, 0, 4'b1111, 0, 0, 0, 0, -1);
    drive(1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0001);
    drive(1, 0, 0, 4'b0111, 0, 0, 0, 0, 4'b1000);
    // Flush blocks LFSR, pointer and invalidate updates.
    drive(1, 0, 0, 4'b1111, 1, 1, 1, 0, -1);
    drive(1, 0, 0, 4'b1111, 0, 0, 0, 0, -1);

    // Reset during a fill after three fills.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'b1111, 1, 0, 0, 0, lfsr_seq[i]);
    drive(0, 0, 0, 4'b1111, 1, 0, 0, 0, -1);
    drive(1, 0, 0, 4'b1111, 0, 0, 0, 0, 4'b0010);

`ifdef CACHE_REPL_RR_EN
    do_reset();
    drive(1, 1, 5, 4'b1111, 0, 0, 0, 1, 4'b0001);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 4'b1111, 1, 0, 0, 1, rr_seq[i]);
    drive(1, 1, 6, 4'b1111, 0, 0, 0, 1, 4'b0010);
    drive(1, 1, 5, 4'b1111, 0, 0, 0, 1, 4'b0001);
    drive(1, 0, 0, 4'b1111, 1, 0, 0, 1, 4'b0010);
    drive(1, 0, 0, 4'b1111, 1, 0, 1, 1, 4'b0100);
    drive(1, 0, 0, 4'b1111, 0, 0, 0, 1, 4'b0001);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [NW-1:0] vw;
      vw = ($urandom_range(0, 1) == 0) ? 4'b1111 : NW'($urandom_range(0, 15));
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 2) == 0),
            $urandom_range(0, 7),
            vw,
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1) == 0),
            -1);
    end

    @(posedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_repl.md
CACHE_REPL -- requirements
Module: cache_repl

Interface
REQ-001 Parameter NUMWAYS, default 4: ways per set; power of 2, 2..16.
REQ-002 Parameter SETLEN, default 7: set index width; NUMLINES = 2**SETLEN.
REQ-003 Parameter LFSRWIDTH, default 8: LFSR width; legal values 8 or 16.
REQ-004 Parameter SEED, default 1: LFSR reset value; nonzero; masked to LFSRWIDTH bits.
REQ-005 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 Port resetn, input, 1: reset, synchronous and active-low.
REQ-007 Port CacheEn, input, 1: when high, capture CacheSet; low = stall.
REQ-008 Port CacheSet, input, SETLEN: set index of the access.
REQ-009 Port ValidWay, input, NUMWAYS: valid bits of the set held in SetReg.
REQ-010 Port FillEn, input, 1: line fill into the victim way this cycle.
REQ-011 Port FlushStage, input, 1: suppresses every state update this cycle.
REQ-012 Port InvalidateCache, input, 1: clears all per-set pointers (RR build only).
REQ-013 Port PolicySel, input, 1: 0 = LFSR random, 1 = round-robin; ignored without macro.
REQ-014 Port VictimWay, output, NUMWAYS: one-hot way to evict.

Function
REQ-015 SetReg SHALL load CacheSet on each edge with CacheEn=1 and hold otherwise; LOGNUMWAYS = log2(NUMWAYS).
REQ-016 AllValid = AND of ValidWay; if AllValid=0, VictimWay SHALL be one-hot of lowest-index zero in ValidWay, regardless of policy.
REQ-017 If AllValid=1 and random policy, victim index SHALL be Lfsr[LOGNUMWAYS-1:0].
REQ-018 If AllValid=1 and round-robin policy, victim index SHALL be Ptr[SetReg].
REQ-019 VictimWay SHALL be combinational from SetReg, state and ValidWay (0-cycle latency vs ValidWay); exactly one bit high at all times.
REQ-020 Lfsr SHALL be Fibonacci, shift left, new bit into bit 0; feedback = XOR of bits 7,5,4,3 (width 8) or bits 15,14,12,3 (width 16).
REQ-021 Lfsr SHALL advance one step on every edge with FillEn=1 and FlushStage=0, independent of PolicySel and AllValid.
REQ-022 Ptr[SetReg] SHALL increment modulo NUMWAYS on an edge with FillEn=1, FlushStage=0, AllValid=1, InvalidateCache=0; fills into invalid ways leave Ptr unchanged.
REQ-023 InvalidateCache=1 with FlushStage=0 SHALL zero all NUMLINES pointers in one cycle; takes priority over a simultaneous fill update; Lfsr still advances.
REQ-024 FlushStage=1 SHALL block Lfsr, Ptr and invalidate updates; SetReg capture still follows CacheEn.
REQ-025 Lfsr SHALL never reach zero; a zero SEED is an elaboration error.

Reset
REQ-026 On edge with resetn=0: Lfsr=SEED, SetReg=0, all Ptr=0; reset overrides all other inputs.
REQ-027 Reset mid-fill SHALL discard that fill's update; first post-reset victim with ValidWay all ones SHALL be way SEED[LOGNUMWAYS-1:0].

Configuration
REQ-028 Macro CACHE_REPL_RR_EN defined: Ptr array (NUMLINES x LOGNUMWAYS flops), PolicySel and InvalidateCache functional.
REQ-029 Macro undefined: no Ptr storage; PolicySel and InvalidateCache ignored; policy always random; ports retained.

Verification (NUMWAYS=4, SETLEN=7, LFSRWIDTH=8, SEED=1)
REQ-030 Reset, ValidWay=1111, PolicySel=0, five FillEn pulses -> VictimWay before each: 0010, 0100, 0001, 0001, 0010 (Lfsr 01,02,04,08,11).
REQ-031 ValidWay=1011 with FillEn pulses -> VictimWay=0100 every cycle; Lfsr still advances.
REQ-032 RR build, PolicySel=1, SetReg=5, ValidWay=1111, five fills -> VictimWay 0001,0010,0100,1000,0001; Ptr[6] remains 0.
REQ-033 RR build, Ptr[5]=2, InvalidateCache=1 with FillEn=1 -> next cycle Ptr[5]=0, VictimWay=0001.
REQ-034 FlushStage=1 with FillEn=1 and InvalidateCache=1 -> Lfsr and all Ptr unchanged.
REQ-035 resetn=0 during FillEn=1 after three fills -> next cycle Lfsr=01, Ptr all 0, VictimWay=0010 with ValidWay=1111, PolicySel=0.
